timer_irq_unit: RTL and testbench

- Memory-mapped interval timer on the single-cycle MIPS data bus.
- Produces the IRQ line consumed by the control unit; the control unit takes the interrupt only when the kernel bit is clear.
- Software programs the reload value (TH), the counter (TL) and the control/status register (TCON) with lw/sw.
- Reads return data in the same cycle, so they fit the single-cycle datapath.

---
 rtl/timer_irq_unit.sv | 145 ++++++++++++++
 tb/tb_timer_irq_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_unit.sv
// ---------------------------------------------------------------------------
// timer_irq_unit
//
// Memory-mapped interval timer for the single-cycle MIPS data bus. It holds a
// reload value (TH), an up-counter (TL) and a control/status register (TCON),
// and drives the interrupt request line that the control unit consumes.
//
// Register map (byte addresses, word aligned):
//   BASE_ADDR + 0  : TH   reload value
//   BASE_ADDR + 4  : TL   counter
//   BASE_ADDR + 8  : TCON [0] enable, [1] interrupt enable, [2] status (sticky)
//   BASE_ADDR + 12 : SYSTICK free-running counter, read-only
//                    (present only when SYSTICK_EN is defined)
//
// Optional feature macro: SYSTICK_EN
//
// Parameters:
//   BASE_ADDR  byte address of TH
//   PRESCALE   clock cycles per TL increment (1..65535)
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   reset     synchronous, active-low reset
//   MemRead   bus read strobe
//   MemWrite  bus write strobe
//   addr      byte address
//   wdata     store data
//   rdata     combinational read data (0 unless MemRead and hit)
//   hit       addr selects a register of this block
//   IRQ       interrupt request = TCON[1] & TCON[2]
// ---------------------------------------------------------------------------
module timer_irq_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        IRQ
);

    localparam logic [15:0] PCNT_LAST = 16'(PRESCALE - 1);

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [15:0] pcnt;

    logic sel_th;
    logic sel_tl;
    logic sel_tcon;
    logic sel_systick;
    logic wr;
    logic tick;
    logic overflow;

    assign sel_th   = (addr == BASE_ADDR);
    assign sel_tl   = (addr == BASE_ADDR + 32'd4);
    assign sel_tcon = (addr == BASE_ADDR + 32'd8);

`ifdef SYSTICK_EN
    logic [31:0] systick;

    assign sel_systick = (addr == BASE_ADDR + 32'd12);

    // Free-running; any write that decodes here is simply dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            systick <= 32'd0;
        end else begin
            systick <= systick + 32'd1;
        end
    end
`else
    assign sel_systick = 1'b0;
`endif

    // Outputs read as zero while reset is held low.
    assign hit = reset & (sel_th | sel_tl | sel_tcon | sel_systick);
    assign wr  = MemWrite & hit;

    assign tick     = tcon[0] & (pcnt == PCNT_LAST);
    assign overflow = tick & (tl == 32'hFFFF_FFFF);

    assign IRQ = tcon[1] & tcon[2];

    always_ff @(posedge clk) begin
        if (!reset) begin
            th   <= 32'd0;
            tl   <= 32'd0;
            tcon <= 3'd0;
            pcnt <= 16'd0;
        end else begin
            if (!tcon[0] || pcnt == PCNT_LAST) begin
                pcnt <= 16'd0;
            end else begin
                pcnt <= pcnt + 16'd1;
            end

            // A reload in this same cycle still sees the old TH.
            if (wr && sel_th) begin
                th <= wdata;
            end

            // CPU write to TL beats both increment and reload.
            if (wr && sel_tl) begin
                tl <= wdata;
            end else if (tick) begin
                tl <= (tl == 32'hFFFF_FFFF) ? th : tl + 32'd1;
            end

            // CPU write to TCON wins entirely; a coincident status set is lost.
            if (wr && sel_tcon) begin
                tcon <= wdata[2:0];
            end else if (overflow && tcon[1]) begin
                tcon[2] <= 1'b1;
            end
        end
    end

    // Zero-latency read mux; with a simultaneous write this shows the old value.
    always_comb begin
        rdata = 32'd0;
        if (MemRead && hit) begin
            if (sel_th) begin
                rdata = th;
            end else if (sel_tl) begin
                rdata = tl;
            end else if (sel_tcon) begin
                rdata = {29'd0, tcon};
            end
`ifdef SYSTICK_EN
            else if (sel_systick) begin
                rdata = systick;
            end
`endif
        end
    end

endmodule

// File: tb/tb_timer_irq_unit.sv
// ---------------------------------------------------------------------------
// tb_timer_irq_unit
//
// Two timer instances (PRESCALE 1 and 4) share one bus. Each step drives the
// bus away from the clock edge, compares rdata/hit/IRQ of both instances with
// a behavioural model, then advances the model over the clock edge.
// ---------------------------------------------------------------------------
module tb_timer_irq_unit;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;

    logic [31:0] rdata_p1;
    logic        hit_p1;
    logic        irq_p1;
    logic [31:0] rdata_p4;
    logic        hit_p4;
    logic        irq_p4;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    timer_irq_unit #(.BASE_ADDR(BASE), .PRESCALE(1)) u_p1 (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .wdata(wdata), .rdata(rdata_p1), .hit(hit_p1), .IRQ(irq_p1)
    );

    timer_irq_unit #(.BASE_ADDR(BASE), .PRESCALE(4)) u_p4 (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .wdata(wdata), .rdata(rdata_p4), .hit(hit_p4), .IRQ(irq_p4)
    );

    // ---------------- reference model ----------------
    int          m_pre [2] = '{1, 4};
    logic [31:0] m_th  [2] = '{32'd0, 32'd0};
    logic [31:0] m_tl  [2] = '{32'd0, 32'd0};
    logic [2:0]  m_tcon[2] = '{3'd0, 3'd0};
    int          m_en_cycles[2] = '{0, 0};  // enabled cycles since last disable
    logic [31:0] m_st = 32'd0;

    function automatic logic m_hit(input logic [31:0] a);
        logic h;
        h = (a == BASE) || (a == BASE + 32'd4) || (a == BASE + 32'd8);
`ifdef SYSTICK_EN
        h = h || (a == BASE + 32'd12);
`endif
        return h;
    endfunction

    function automatic logic [31:0] m_reg(input int k, input logic [31:0] a);
        if (a == BASE) return m_th[k];
        if (a == BASE + 32'd4) return m_tl[k];
        if (a == BASE + 32'd8) return {29'd0, m_tcon[k]};
`ifdef SYSTICK_EN
        if (a == BASE + 32'd12) return m_st;
`endif
        return 32'd0;
    endfunction

    task automatic model_edge(input logic r, input logic mw, input logic [31:0] a,
                              input logic [31:0] d);
        logic        tk;
        logic [31:0] n_th;
        logic [31:0] n_tl;
        logic [2:0]  n_tcon;
        for (int k = 0; k < 2; k++) begin
            if (!r) begin
                m_th[k] = 0; m_tl[k] = 0; m_tcon[k] = 0; m_en_cycles[k] = 0;
            end else begin
                tk = m_tcon[k][0] && ((m_en_cycles[k] % m_pre[k]) == m_pre[k] - 1);
                n_th = m_th[k]; n_tl = m_tl[k]; n_tcon = m_tcon[k];
                if (tk) begin
                    if (m_tl[k] == 32'hFFFF_FFFF) begin
                        n_tl = m_th[k];
                        if (m_tcon[k][1]) n_tcon[2] = 1'b1;
                    end else begin
                        n_tl = m_tl[k] + 1;
                    end
                end
                if (mw && a == BASE) n_th = d;
                if (mw && a == BASE + 32'd4) n_tl = d;
                if (mw && a == BASE + 32'd8) n_tcon = d[2:0];
                m_en_cycles[k] = m_tcon[k][0] ? (m_en_cycles[k] + 1) % m_pre[k] : 0;
                m_th[k] = n_th; m_tl[k] = n_tl; m_tcon[k] = n_tcon;
            end
        end
        m_st = r ? m_st + 1 : 32'd0;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic mr, input logic mw,
                        input logic [31:0] a, input logic [31:0] d);
        logic        e_hit;
        logic [31:0] e_rd;
        @(negedge clk);
        reset = r; MemRead = mr; MemWrite = mw; addr = a; wdata = d;
        #1;
        e_hit = r && m_hit(a);
        for (int k = 0; k < 2; k++) begin
            e_rd = (mr && e_hit) ? m_reg(k, a) : 32'd0;
            chk(k == 0 ? "p1_hit" : "p4_hit", {31'd0, k == 0 ? hit_p1 : hit_p4}, {31'd0, e_hit});
            chk(k == 0 ? "p1_rdata" : "p4_rdata", k == 0 ? rdata_p1 : rdata_p4, e_rd);
            chk(k == 0 ? "p1_irq" : "p4_irq", {31'd0, k == 0 ? irq_p1 : irq_p4},
                {31'd0, m_tcon[k][1] & m_tcon[k][2]});
        end
        @(posedge clk);
        model_edge(r, mw, a, d);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 1'b1, 1'b0, a, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        r;
        logic        mr;
        logic        mw;

        // Flops are unknown before the first reset edge; no checks yet.
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Reset outputs, even with a read of TCON in flight.
        step(1'b0, 1'b1, 1'b0, BASE + 32'd8, 32'd0);
        step(1'b0, 1'b1, 1'b0, BASE + 32'd8, 32'd0);

        // Post-reset reads and decode boundaries.
        rd(BASE + 32'd8);
        rd(BASE + 32'd12);
        rd(BASE + 32'd1);
        rd(BASE + 32'd6);
        rd(BASE + 32'd16);
        rd(BASE - 32'd4);

        // Overflow/reload with interrupt.
        wr(BASE, 32'hFFFF_FFFC);
        wr(BASE + 32'd4, 32'hFFFF_FFFC);
        wr(BASE + 32'd8, 32'd3);
        repeat (6) rd(BASE + 32'd4);
        rd(BASE + 32'd8);

        // Clear pending status with a simultaneous read (old value shown).
        step(1'b1, 1'b1, 1'b1, BASE + 32'd8, 32'd3);
        repeat (6) rd(BASE + 32'd4);

        // Prescaled counting with interrupt disabled, across an overflow.
        wr(BASE + 32'd8, 32'd0);
        wr(BASE + 32'd4, 32'd0);
        wr(BASE + 32'd8, 32'd1);
        repeat (10) rd(BASE + 32'd4);
        wr(BASE + 32'd4, 32'hFFFF_FFFD);
        repeat (20) rd(BASE + 32'd8);

        // Same-edge collisions (exact edge for the PRESCALE=1 instance).
        wr(BASE + 32'd8, 32'd3);
        wr(BASE + 32'd4, 32'hFFFF_FFFF);
        wr(BASE + 32'd4, 32'd5);
        rd(BASE + 32'd4);
        rd(BASE + 32'd8);
        wr(BASE + 32'd4, 32'hFFFF_FFFF);
        wr(BASE + 32'd8, 32'd3);
        rd(BASE + 32'd8);
        rd(BASE + 32'd4);
        wr(BASE, 32'hFFFF_FFF0);
        wr(BASE + 32'd4, 32'hFFFF_FFFF);
        wr(BASE, 32'h0000_0100);
        repeat (3) rd(BASE + 32'd4);

        // Reset mid-count.
        wr(BASE + 32'd4, 32'h10);
        wr(BASE + 32'd8, 32'd7);
        rd(BASE + 32'd4);
        step(1'b0, 1'b1, 1'b0, BASE + 32'd4, 32'd0);
        rd(BASE + 32'd4);
        rd(BASE + 32'd8);
        repeat (3) rd(BASE + 32'd12);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0: a = BASE;
                1: a = BASE + 32'd4;
                2: a = BASE + 32'd8;
                3: a = BASE + 32'd12;
                4: a = BASE + 32'd1;
                5: a = BASE + 32'd2;
                6: a = BASE - 32'd4;
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 1) == 0) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else d = $urandom;
            if (a == BASE + 32'd8) d = 32'($urandom_range(1, 7));
            r  = ($urandom_range(0, 49) != 0);
            mr = ($urandom_range(0, 1) == 1);
            mw = ($urandom_range(0, 3) == 0);
            step(r, mr, mw, a, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
